// File: rtl/ahb_sram_arb2.sv
// ---------------------------------------------------------------------------
// ahb_sram_arb2
//   Two-master (M0 = CPU, M1 = DMA) to one-slave AHB-Lite arbiter in front of
//   the SRAM controller. When both masters present an address phase that
//   cannot be forwarded together, the losing address/control is parked in a
//   per-port hold buffer and replayed later. The parked master sees
//   HREADYOUT low until its transfer has been forwarded. A transfer nobody
//   competes with goes straight through in the same cycle.
//
//   Handshake: a master request is HSEL & HREADY & HTRANS[1]. A slave
//   address phase is issued only in a cycle with HREADYOUT_S high; a master
//   whose request is not forwarded in that cycle is captured and stalled.
//
// Parameters
//   AW : address width forwarded to the slave
//   RR : 1 = round-robin between equal-rank candidates, 0 = M0 always wins
//
// Ports
//   HCLK, HRESET           clock, asynchronous active-high reset
//   H*_M0 / H*_M1          master-side AHB-Lite address/data inputs
//   HRDATA_Mx, HREADYOUT_Mx  master-side responses
//   H*_S                   slave-side address phase and write data
//   HRDATA_S, HREADYOUT_S  slave response
// ---------------------------------------------------------------------------
module ahb_sram_arb2 #(
  parameter int AW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL_M0,
  input  logic          HSEL_M1,
  input  logic          HREADY_M0,
  input  logic          HREADY_M1,
  input  logic [1:0]    HTRANS_M0,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M0,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M0,
  input  logic [2:0]    HSIZE_M1,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [31:0]   HWDATA_M0,
  input  logic [31:0]   HWDATA_M1,
  output logic [31:0]   HRDATA_M0,
  output logic [31:0]   HRDATA_M1,
  output logic          HREADYOUT_M0,
  output logic          HREADYOUT_M1,
  output logic          HSEL_S,
  output logic          HREADY_S,
  output logic [1:0]    HTRANS_S,
  output logic          HWRITE_S,
  output logic [2:0]    HSIZE_S,
  output logic [AW-1:0] HADDR_S,
  output logic [31:0]   HWDATA_S,
  input  logic [31:0]   HRDATA_S,
  input  logic          HREADYOUT_S
);

  // Held address/control per port
  logic [1:0]    hold_vld_q, hold_vld_d;
  logic [AW-1:0] hold_addr_q [2];
  logic [AW-1:0] hold_addr_d [2];
  logic [1:0]    hold_write_q, hold_write_d;
  logic [2:0]    hold_size_q [2];
  logic [2:0]    hold_size_d [2];

  logic last_gnt_q, last_gnt_d;
  logic dp_vld_q, dp_vld_d;
  logic dp_own_q, dp_own_d;

  logic [AW-1:0] live_addr [2];
  logic [1:0]    live_write;
  logic [2:0]    live_size [2];
  logic [1:0]    live_req;
  logic [1:0]    cand;
  logic [1:0]    capture;
  logic [1:0]    rdy;
  logic          gnt_vld;
  logic          gnt_idx;
  logic [AW-1:0] sel_addr;
  logic          sel_write;
  logic [2:0]    sel_size;

  // HTRANS[0] only separates SEQ from NONSEQ, which is forced to NONSEQ.
  logic unused_htrans;
  assign unused_htrans = HTRANS_M0[0] ^ HTRANS_M1[0];

  assign live_addr[0]  = HADDR_M0;
  assign live_addr[1]  = HADDR_M1;
  assign live_write    = {HWRITE_M1, HWRITE_M0};
  assign live_size[0]  = HSIZE_M0;
  assign live_size[1]  = HSIZE_M1;

  // A held port is stalled, so any live request it shows is ignored. Reset
  // masks live requests so the slave side is idle while HRESET is high.
  assign live_req[0] = HSEL_M0 & HREADY_M0 & HTRANS_M0[1] & ~hold_vld_q[0] & ~HRESET;
  assign live_req[1] = HSEL_M1 & HREADY_M1 & HTRANS_M1[1] & ~hold_vld_q[1] & ~HRESET;
  assign cand        = hold_vld_q | live_req;

  // Grant: a replayed transfer outranks a fresh one; equal ranks are split
  // by round-robin (port other than last_gnt) or fixed M0 priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (HREADYOUT_S) begin
      if (cand[0] & cand[1]) begin
        gnt_vld = 1'b1;
        if (hold_vld_q[0] != hold_vld_q[1]) gnt_idx = hold_vld_q[1];
        else if (RR)                        gnt_idx = ~last_gnt_q;
        else                                gnt_idx = 1'b0;
      end else if (cand[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end else if (cand[1]) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  always_comb begin
    if (hold_vld_q[gnt_idx]) begin
      sel_addr  = hold_addr_q[gnt_idx];
      sel_write = hold_write_q[gnt_idx];
      sel_size  = hold_size_q[gnt_idx];
    end else begin
      sel_addr  = live_addr[gnt_idx];
      sel_write = live_write[gnt_idx];
      sel_size  = live_size[gnt_idx];
    end
  end

  assign capture[0] = live_req[0] & ~(gnt_vld & (gnt_idx == 1'b0));
  assign capture[1] = live_req[1] & ~(gnt_vld & (gnt_idx == 1'b1));

  // Slave address phase
  assign HSEL_S   = gnt_vld;
  assign HTRANS_S = gnt_vld ? 2'b10 : 2'b00;
  assign HADDR_S  = gnt_vld ? sel_addr : '0;
  assign HWRITE_S = gnt_vld & sel_write;
  assign HSIZE_S  = gnt_vld ? sel_size : 3'b000;

  // Masters hold HWDATA stable while stalled, so the data phase simply
  // selects the owner's bus.
  assign HWDATA_S  = dp_own_q ? HWDATA_M1 : HWDATA_M0;
  assign HREADY_S  = HREADYOUT_S;
  assign HRDATA_M0 = HRDATA_S;
  assign HRDATA_M1 = HRDATA_S;

  always_comb begin
    rdy = 2'b11;
    for (int i = 0; i < 2; i++) begin
      if (hold_vld_q[i] | capture[i])             rdy[i] = 1'b0;
      else if (dp_vld_q & (dp_own_q == 1'(i)))    rdy[i] = HREADYOUT_S;
      else                                        rdy[i] = 1'b1;
    end
  end
  assign HREADYOUT_M0 = rdy[0];
  assign HREADYOUT_M1 = rdy[1];

  always_comb begin
    hold_vld_d   = hold_vld_q;
    hold_addr_d  = hold_addr_q;
    hold_write_d = hold_write_q;
    hold_size_d  = hold_size_q;
    last_gnt_d   = last_gnt_q;
    dp_vld_d     = dp_vld_q;
    dp_own_d     = dp_own_q;
    for (int i = 0; i < 2; i++) begin
      if (capture[i]) begin
        hold_vld_d[i]   = 1'b1;
        hold_addr_d[i]  = live_addr[i];
        hold_write_d[i] = live_write[i];
        hold_size_d[i]  = live_size[i];
      end else if (gnt_vld & (gnt_idx == 1'(i))) begin
        hold_vld_d[i] = 1'b0;
      end
    end
    if (gnt_vld) begin
      last_gnt_d = gnt_idx;
      dp_vld_d   = 1'b1;
      dp_own_d   = gnt_idx;
    end else if (HREADYOUT_S) begin
      dp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_vld_q   <= 2'b00;
      hold_addr_q  <= '{default: '0};
      hold_write_q <= 2'b00;
      hold_size_q  <= '{default: '0};
      last_gnt_q   <= 1'b1;
      dp_vld_q     <= 1'b0;
      dp_own_q     <= 1'b0;
    end else begin
      hold_vld_q   <= hold_vld_d;
      hold_addr_q  <= hold_addr_d;
      hold_write_q <= hold_write_d;
      hold_size_q  <= hold_size_d;
      last_gnt_q   <= last_gnt_d;
      dp_vld_q     <= dp_vld_d;
      dp_own_q     <= dp_own_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_arb2.sv
`timescale 1ns/1ps
// Bench for ahb_sram_arb2: one instance per arbitration mode, a small SRAM
// slave model, a transaction-level reference model and a negedge monitor.
module tb_ahb_sram_arb2;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic          HSEL_M0, HSEL_M1, HREADY_M0, HREADY_M1;
  logic [1:0]    HTRANS_M0, HTRANS_M1;
  logic          HWRITE_M0, HWRITE_M1;
  logic [2:0]    HSIZE_M0, HSIZE_M1;
  logic [AW-1:0] HADDR_M0, HADDR_M1;
  logic [31:0]   HWDATA_M0, HWDATA_M1;
  logic [31:0]   HRDATA_S;
  logic          HREADYOUT_S;

  logic [31:0] r1_rd0, r1_rd1, r0_rd0, r0_rd1;
  logic r1_ro0, r1_ro1, r0_ro0, r0_ro1;
  logic r1_sel, r0_sel, r1_rdys, r0_rdys, r1_wr, r0_wr;
  logic [1:0] r1_tr, r0_tr;
  logic [2:0] r1_sz, r0_sz;
  logic [AW-1:0] r1_ad, r0_ad;
  logic [31:0] r1_wd, r0_wd;

  ahb_sram_arb2 #(.AW(AW), .RR(1'b1)) u_rr1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_M0(HSEL_M0), .HSEL_M1(HSEL_M1), .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1), .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1), .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1), .HRDATA_M0(r1_rd0), .HRDATA_M1(r1_rd1),
    .HREADYOUT_M0(r1_ro0), .HREADYOUT_M1(r1_ro1), .HSEL_S(r1_sel), .HREADY_S(r1_rdys),
    .HTRANS_S(r1_tr), .HWRITE_S(r1_wr), .HSIZE_S(r1_sz), .HADDR_S(r1_ad), .HWDATA_S(r1_wd),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S));

  ahb_sram_arb2 #(.AW(AW), .RR(1'b0)) u_rr0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_M0(HSEL_M0), .HSEL_M1(HSEL_M1), .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1), .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1), .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1), .HRDATA_M0(r0_rd0), .HRDATA_M1(r0_rd1),
    .HREADYOUT_M0(r0_ro0), .HREADYOUT_M1(r0_ro1), .HSEL_S(r0_sel), .HREADY_S(r0_rdys),
    .HTRANS_S(r0_tr), .HWRITE_S(r0_wr), .HSIZE_S(r0_sz), .HADDR_S(r0_ad), .HWDATA_S(r0_wd),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S));

  // sel0 = 1 puts the fixed-priority instance on the slave model and checker
  logic sel0 = 1'b0;
  logic [31:0] a_rd0, a_rd1, a_wd;
  logic a_ro0, a_ro1, a_sel, a_rdys, a_wr;
  logic [1:0] a_tr;
  logic [2:0] a_sz;
  logic [AW-1:0] a_ad;
  assign a_rd0  = sel0 ? r0_rd0  : r1_rd0;
  assign a_rd1  = sel0 ? r0_rd1  : r1_rd1;
  assign a_ro0  = sel0 ? r0_ro0  : r1_ro0;
  assign a_ro1  = sel0 ? r0_ro1  : r1_ro1;
  assign a_sel  = sel0 ? r0_sel  : r1_sel;
  assign a_rdys = sel0 ? r0_rdys : r1_rdys;
  assign a_tr   = sel0 ? r0_tr   : r1_tr;
  assign a_wr   = sel0 ? r0_wr   : r1_wr;
  assign a_sz   = sel0 ? r0_sz   : r1_sz;
  assign a_ad   = sel0 ? r0_ad   : r1_ad;
  assign a_wd   = sel0 ? r0_wd   : r1_wd;

  // ---------------- SRAM slave model ----------------
  logic [31:0] smem [256];
  logic        s_rdy, s_dpv, s_dwr;
  logic [7:0]  s_didx;
  assign HREADYOUT_S = s_rdy;
  assign HRDATA_S    = smem[s_didx];
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_dpv  <= 1'b0;
      s_dwr  <= 1'b0;
      s_didx <= 8'd0;
    end else if (s_rdy) begin
      if (s_dpv && s_dwr) smem[s_didx] <= a_wd;
      s_dpv  <= a_sel && a_tr[1];
      s_dwr  <= a_wr;
      s_didx <= a_ad[9:2];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [2:0]    size;
    logic [31:0]   wdata;
  } txn_t;

  typedef struct packed {
    logic          hsel;
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic          rdy0;
    logic          rdy1;
    logic          rchk;
    logic [31:0]   rdata;
  } exp_t;

  exp_t exp_q[$];

  logic        m_hv [2];
  txn_t        m_hold [2];
  int          m_last;
  logic        m_dpv;
  int          m_dpo;
  txn_t        m_dp;
  logic [31:0] m_wd [2];
  logic [31:0] gmem [256];

  // per-cycle stimulus
  logic       st_sel [2];
  logic       st_rdy [2];
  logic [1:0] st_tr [2];
  txn_t       st_t [2];
  logic       srdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m_hv[i] = 1'b0;
    m_last = 1;
    m_dpv  = 1'b0;
    m_dpo  = 0;
  endtask

  task automatic drive();
    HSEL_M0 = st_sel[0]; HREADY_M0 = st_rdy[0]; HTRANS_M0 = st_tr[0];
    HWRITE_M0 = st_t[0].wr; HSIZE_M0 = st_t[0].size; HADDR_M0 = st_t[0].addr;
    HSEL_M1 = st_sel[1]; HREADY_M1 = st_rdy[1]; HTRANS_M1 = st_tr[1];
    HWRITE_M1 = st_t[1].wr; HSIZE_M1 = st_t[1].size; HADDR_M1 = st_t[1].addr;
    HWDATA_M0 = m_wd[0];
    HWDATA_M1 = m_wd[1];
    s_rdy = srdy;
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      st_sel[i] = 1'b0; st_rdy[i] = 1'b1; st_tr[i] = 2'b00;
      st_t[i] = '0;
    end
    srdy = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [31:0] d);
    st_sel[i] = 1'b1; st_rdy[i] = 1'b1; st_tr[i] = 2'b10;
    st_t[i].addr = a; st_t[i].wr = w; st_t[i].size = 3'b010; st_t[i].wdata = d;
  endtask

  // Called at posedge+1: drive this cycle, predict the response, advance
  // the model, then move to the next posedge+1.
  task automatic apply_cycle();
    logic req [2];
    logic g;
    int   w;
    txn_t gt;
    exp_t e;
    for (int i = 0; i < 2; i++) if (m_hv[i]) st_rdy[i] = 1'b0;  // stalled master
    drive();
    for (int i = 0; i < 2; i++)
      req[i] = st_sel[i] && st_rdy[i] && st_tr[i][1] && !m_hv[i];
    g = 1'b0; w = 0;
    if (srdy) begin
      if ((m_hv[0] || req[0]) && (m_hv[1] || req[1])) begin
        g = 1'b1;
        if (m_hv[0] && !m_hv[1])      w = 0;
        else if (m_hv[1] && !m_hv[0]) w = 1;
        else if (!sel0)               w = (m_last == 0) ? 1 : 0;
        else                          w = 0;
      end else if (m_hv[0] || req[0]) begin
        g = 1'b1; w = 0;
      end else if (m_hv[1] || req[1]) begin
        g = 1'b1; w = 1;
      end
    end
    gt = m_hv[w] ? m_hold[w] : st_t[w];
    e.hsel   = g;
    e.htrans = g ? 2'b10 : 2'b00;
    e.haddr  = g ? gt.addr : '0;
    e.hwrite = g ? gt.wr : 1'b0;
    e.hsize  = g ? gt.size : 3'b000;
    e.hwdata = m_wd[m_dpo];
    e.rdy0 = (m_hv[0] || (req[0] && !(g && w == 0))) ? 1'b0 : ((m_dpv && m_dpo == 0) ? srdy : 1'b1);
    e.rdy1 = (m_hv[1] || (req[1] && !(g && w == 1))) ? 1'b0 : ((m_dpv && m_dpo == 1) ? srdy : 1'b1);
    e.rchk  = m_dpv && srdy && !m_dp.wr;
    e.rdata = gmem[m_dp.addr[9:2]];
    exp_q.push_back(e);
    // state advance
    if (m_dpv && srdy && m_dp.wr) gmem[m_dp.addr[9:2]] = m_wd[m_dpo];
    if (g) m_hv[w] = 1'b0;
    for (int i = 0; i < 2; i++)
      if (req[i] && !(g && w == i)) begin
        m_hv[i]   = 1'b1;
        m_hold[i] = st_t[i];
      end
    if (g) begin
      m_last = w; m_dpv = 1'b1; m_dpo = w; m_dp = gt; m_wd[w] = gt.wdata;
    end else if (srdy) begin
      m_dpv = 1'b0;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      apply_cycle();
    end
  endtask

  // Reset checks happen while HRESET is high, so nothing is queued.
  task automatic reset_checks();
    check("rst_hreadyout_m0", a_ro0, 1'b1);
    check("rst_hreadyout_m1", a_ro1, 1'b1);
    check("rst_hsel_s", a_sel, 1'b0);
    check("rst_htrans_s", a_tr, 2'b00);
    check("rst_hready_s", a_rdys, s_rdy);
    check("rst_hwdata_s", a_wd, HWDATA_M0);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    m_wd[0] = $urandom; m_wd[1] = $urandom;
    set_idle();
    drive();
    #2;
    reset_checks();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    model_reset();
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        st_sel[i] = ($urandom_range(0, 3) != 0);
        st_rdy[i] = ($urandom_range(0, 7) != 0);
        st_tr[i]  = {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1))};
        st_t[i].addr  = AW'($urandom_range(0, 255)) << 2;
        st_t[i].wr    = 1'($urandom_range(0, 1));
        st_t[i].size  = 3'($urandom_range(0, 7));
        st_t[i].wdata = $urandom;
      end
      srdy = ($urandom_range(0, 3) != 0);
      apply_cycle();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESET && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hsel_s", a_sel, e.hsel);
      check("htrans_s", a_tr, e.htrans);
      check("haddr_s", a_ad, e.haddr);
      check("hwrite_s", a_wr, e.hwrite);
      check("hsize_s", a_sz, e.hsize);
      check("hwdata_s", a_wd, e.hwdata);
      check("hreadyout_m0", a_ro0, e.rdy0);
      check("hreadyout_m1", a_ro1, e.rdy1);
      check("hready_s", a_rdys, s_rdy);
      if (e.rchk) begin
        check("hrdata_m0", a_rd0, e.rdata);
        check("hrdata_m1", a_rd1, e.rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 256; k++) begin
      smem[k] = 32'h0;
      gmem[k] = 32'h0;
    end
    HRESET = 1'b1;
    set_idle();
    m_wd[0] = 32'h0; m_wd[1] = 32'h0;
    drive();
    @(posedge HCLK);
    #1;
    do_reset();

    // M0 writes, then M1 reads the same word back
    set_idle(); set_req(0, 32'h100, 1'b1, 32'hDEADBEEF); apply_cycle();
    idle_cycles(1);
    set_idle(); set_req(1, 32'h100, 1'b0, 32'h0); apply_cycle();
    idle_cycles(2);

    // simultaneous writes straight after reset, then read both back
    do_reset();
    set_idle();
    set_req(0, 32'h200, 1'b1, 32'h11111111);
    set_req(1, 32'h204, 1'b1, 32'h22222222);
    apply_cycle();
    idle_cycles(3);
    set_idle(); set_req(0, 32'h200, 1'b0, 32'h0); apply_cycle();
    set_idle(); set_req(1, 32'h204, 1'b0, 32'h0); apply_cycle();
    idle_cycles(2);

    // both ports stream reads for 8 cycles
    for (int k = 0; k < 8; k++) begin
      set_idle();
      set_req(0, 32'h000 + 32'(4 * k), 1'b0, 32'h0);
      set_req(1, 32'h040 + 32'(4 * k), 1'b0, 32'h0);
      apply_cycle();
    end
    idle_cycles(3);

    // slave stalls 3 cycles while M1 issues a write
    set_idle(); set_req(0, 32'h300, 1'b1, 32'h12345678); apply_cycle();
    set_idle(); srdy = 1'b0; set_req(1, 32'h304, 1'b1, 32'hCAFEF00D); apply_cycle();
    set_idle(); srdy = 1'b0; apply_cycle();
    set_idle(); srdy = 1'b0; apply_cycle();
    idle_cycles(2);
    set_idle(); set_req(0, 32'h304, 1'b0, 32'h0); apply_cycle();
    set_idle(); set_req(1, 32'h300, 1'b0, 32'h0); apply_cycle();
    idle_cycles(2);

    random_cycles(300);
    idle_cycles(3);

    // reset while M1 sits in its hold buffer
    set_idle(); srdy = 1'b0; set_req(1, 32'h3F0, 1'b1, 32'h0BADF00D); apply_cycle();
    set_idle(); st_rdy[1] = 1'b0; srdy = 1'b1; drive();
    #1;
    HRESET = 1'b1;
    #1;
    check("async_rst_hreadyout_m1", a_ro1, 1'b1);
    check("async_rst_htrans_s", a_tr, 2'b00);
    check("async_rst_hsel_s", a_sel, 1'b0);
    @(posedge HCLK);
    #1;
    do_reset();
    idle_cycles(2);
    set_idle(); set_req(1, 32'h3F0, 1'b0, 32'h0); apply_cycle();
    idle_cycles(2);

    // fixed-priority instance
    sel0 = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_idle();
      set_req(0, 32'h100 + 32'(4 * k), 1'b0, 32'h0);
      if (k == 1) set_req(1, 32'h100, 1'b0, 32'h0);
      apply_cycle();
    end
    idle_cycles(3);
    random_cycles(300);
    idle_cycles(3);

    @(negedge HCLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
